swervolf_board_io: RTL and testbench

- Parametrised board-I/O front end between the SoC core and the board pins, in the core clock domain.
- Inputs: switches get two-flop synchronisation, per-bit debounce and edge pulses.
- Outputs: LEDs are registered and gated by global PWM dimming; the UART TX pin is driven from an N-way source mux.
- The mux only changes source while the line is idle, so a character in flight is never corrupted.

---
 rtl/swervolf_board_io.sv | 126 ++++++++++++
 tb/tb_swervolf_board_io.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/swervolf_board_io.sv
// swervolf_board_io: board-pin front end with debounced switches, PWM-dimmed LEDs and an idle-safe UART TX mux.
module swervolf_board_io #(
    parameter int SW_WIDTH        = 16,
    parameter int LED_WIDTH       = 16,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int PWM_BITS        = 4,
    parameter int UART_SRCS       = 2,
    localparam int SEL_W          = (UART_SRCS > 1) ? $clog2(UART_SRCS) : 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [SW_WIDTH-1:0]  i_sw,
    output logic [SW_WIDTH-1:0]  o_sw,
    output logic [SW_WIDTH-1:0]  o_sw_rise,
    output logic [SW_WIDTH-1:0]  o_sw_fall,
    input  logic [LED_WIDTH-1:0] i_led,
    input  logic [PWM_BITS-1:0]  i_led_bright,
    output logic [LED_WIDTH-1:0] o_led,
    input  logic [UART_SRCS-1:0] i_uart_tx,
    input  logic [SEL_W-1:0]     i_uart_sel,
    output logic                 o_uart_tx,
    output logic [SEL_W-1:0]     o_uart_cur
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SW_WIDTH-1:0] sw_s1_q, sw_s2_q, sw_q, sw_dly_q, rise_q, fall_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sw_s1_q  <= '0;
            sw_s2_q  <= '0;
            sw_dly_q <= '0;
            rise_q   <= '0;
            fall_q   <= '0;
        end else begin
            sw_s1_q  <= i_sw;
            sw_s2_q  <= sw_s1_q;
            sw_dly_q <= sw_q;
            rise_q   <= sw_q & ~sw_dly_q;
            fall_q   <= ~sw_q & sw_dly_q;
        end
    end

    genvar g;
    generate
        for (g = 0; g < SW_WIDTH; g++) begin : g_deb
            logic [CNT_W-1:0] cnt_q, cnt_d;
            logic             sw_d;
            // Any sample that agrees with the accepted state restarts the stability count.
            always_comb begin
                cnt_d = (sw_s2_q[g] == sw_q[g]) ? '0 : (cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
                sw_d  = (sw_s2_q[g] != sw_q[g] && cnt_q == CNT_MAX) ? sw_s2_q[g] : sw_q[g];
            end
            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    cnt_q   <= '0;
                    sw_q[g] <= 1'b0;
                end else begin
                    cnt_q   <= cnt_d;
                    sw_q[g] <= sw_d;
                end
            end
        end
    endgenerate

    logic [PWM_BITS-1:0]  pwm_q, bright_q;
    logic [LED_WIDTH-1:0] led_q, led_out_q;
    logic                 gate;

    // All-ones needs its own case so full brightness is truly constant-on.
    always_comb gate = (bright_q == '0) ? 1'b0 : (&bright_q) ? 1'b1 : (pwm_q < bright_q);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pwm_q     <= '0;
            bright_q  <= '0;
            led_q     <= '0;
            led_out_q <= '0;
        end else begin
            pwm_q     <= pwm_q + 1'b1;
            bright_q  <= (&pwm_q) ? i_led_bright : bright_q;
            led_q     <= i_led;
            led_out_q <= led_q & {LED_WIDTH{gate}};
        end
    end

    typedef enum logic {IDLE_LOCK, PENDING} state_e;
    state_e           state_q;
    logic [SEL_W-1:0] req, cur_q;
    logic             tx_q, both_idle;

    always_comb begin
        req       = ({1'b0, i_uart_sel} >= (SEL_W + 1)'(UART_SRCS)) ? '0 : i_uart_sel;
        both_idle = i_uart_tx[cur_q] & i_uart_tx[req];
    end

    // The request is re-read every cycle while pending, so a retarget needs no extra state.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE_LOCK;
            cur_q   <= '0;
            tx_q    <= 1'b1;
        end else begin
            tx_q <= i_uart_tx[cur_q];
            case (state_q)
                IDLE_LOCK: state_q <= (req != cur_q) ? PENDING : IDLE_LOCK;
                PENDING: begin
                    if (req == cur_q) begin
                        state_q <= IDLE_LOCK;
                    end else if (both_idle) begin
                        cur_q   <= req;
                        state_q <= IDLE_LOCK;
                    end
                end
            endcase
        end
    end

    assign o_sw       = sw_q;
    assign o_sw_rise  = rise_q;
    assign o_sw_fall  = fall_q;
    assign o_led      = led_out_q;
    assign o_uart_tx  = tx_q;
    assign o_uart_cur = cur_q;
endmodule

// File: tb/tb_swervolf_board_io.sv
// tb_swervolf_board_io: directed self-checking bench for swervolf_board_io.
module tb_swervolf_board_io;
    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] sw_in, sw_out, sw_rise, sw_fall;
    logic [15:0] led_in, led_out;
    logic [3:0]  bright;
    logic [2:0]  utx;
    logic [1:0]  usel, ucur;
    logic        utx_out;
    int          total = 0;
    int          bad = 0;

    swervolf_board_io #(
        .SW_WIDTH(16), .LED_WIDTH(16), .DEBOUNCE_CYCLES(8), .PWM_BITS(4), .UART_SRCS(3)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_sw(sw_in), .o_sw(sw_out), .o_sw_rise(sw_rise),
        .o_sw_fall(sw_fall), .i_led(led_in), .i_led_bright(bright), .o_led(led_out),
        .i_uart_tx(utx), .i_uart_sel(usel), .o_uart_tx(utx_out), .o_uart_cur(ucur)
    );

    initial forever #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        for (int r = 0; r < 3; r++) begin
            tick();
            total++;
            if (sw_out !== 16'h0 || sw_rise !== 16'h0 || sw_fall !== 16'h0) begin
                bad++;
                $display("FAIL reset_sw: sw=%h rise=%h fall=%h expected all 0", sw_out, sw_rise, sw_fall);
            end
            total++;
            if (led_out !== 16'h0) begin
                bad++;
                $display("FAIL reset_led: got %h expected 0000", led_out);
            end
            total++;
            if (utx_out !== 1'b1 || ucur !== 2'd0) begin
                bad++;
                $display("FAIL reset_uart: tx=%b cur=%0d expected tx=1 cur=0", utx_out, ucur);
            end
        end
        sw_in = 16'h0;
        utx = 3'b111;
        rst = 1'b0;
        repeat (12) tick();
        total++;
        if (sw_out !== 16'h0) begin
            bad++;
            $display("FAIL post_reset_sw: got %h expected 0000", sw_out);
        end
    endtask

    task automatic test_debounce();
        int fall_seen = 0;
        sw_in = 16'h0008;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (sw_fall !== 16'h0) fall_seen++;
            if (k == 9) begin
                total++;
                if (sw_out !== 16'h0) begin
                    bad++;
                    $display("FAIL deb_early: got %h expected 0000 at cycle 9", sw_out);
                end
            end
            if (k == 10) begin
                total++;
                if (sw_out !== 16'h0008 || sw_rise !== 16'h0) begin
                    bad++;
                    $display("FAIL deb_accept: sw=%h rise=%h expected sw=0008 rise=0000", sw_out, sw_rise);
                end
            end
            if (k == 11) begin
                total++;
                if (sw_rise !== 16'h0008) begin
                    bad++;
                    $display("FAIL deb_rise: got %h expected 0008", sw_rise);
                end
            end
            if (k == 12) begin
                total++;
                if (sw_rise !== 16'h0) begin
                    bad++;
                    $display("FAIL deb_rise_len: got %h expected 0000", sw_rise);
                end
            end
        end
        total++;
        if (fall_seen !== 0) begin
            bad++;
            $display("FAIL deb_nofall: fall pulses %0d expected 0", fall_seen);
        end
    endtask

    task automatic test_glitch();
        int moved = 0;
        sw_in = 16'h0028;
        repeat (7) begin
            tick();
            if (sw_out !== 16'h0008) moved++;
        end
        sw_in = 16'h0008;
        repeat (20) begin
            tick();
            if (sw_out !== 16'h0008) moved++;
        end
        total++;
        if (moved !== 0) begin
            bad++;
            $display("FAIL glitch: o_sw left 0008 in %0d cycles expected 0", moved);
        end
    endtask

    task automatic test_simultaneous();
        int fall_seen = 0;
        sw_in = 16'h0009;
        for (int k = 1; k <= 14; k++) begin
            tick();
            if (k == 2) sw_in = 16'h000B;
            if (sw_fall !== 16'h0) fall_seen++;
            if (k == 11 || k == 12 || k == 13 || k == 14) begin
                total++;
                if (sw_rise !== ((k == 11) ? 16'h0001 : (k == 13) ? 16'h0002 : 16'h0000)) begin
                    bad++;
                    $display("FAIL simul_rise: cycle %0d got %h", k, sw_rise);
                end
            end
        end
        total++;
        if (fall_seen !== 0 || sw_out !== 16'h000B) begin
            bad++;
            $display("FAIL simul_state: sw=%h falls=%0d expected sw=000B falls=0", sw_out, fall_seen);
        end
    endtask

    task automatic test_fall();
        sw_in = 16'h000A;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (k == 11) begin
                total++;
                if (sw_fall !== 16'h0001 || sw_out !== 16'h000A) begin
                    bad++;
                    $display("FAIL fall_pulse: fall=%h sw=%h expected fall=0001 sw=000A", sw_fall, sw_out);
                end
            end
            if (k == 12) begin
                total++;
                if (sw_fall !== 16'h0) begin
                    bad++;
                    $display("FAIL fall_len: got %h expected 0000", sw_fall);
                end
            end
        end
    endtask

    task automatic test_pwm();
        logic [15:0] prev, exp;
        int found = 0;
        led_in = 16'h00FF;
        bright = 4'd4;
        repeat (40) tick();
        prev = led_out;
        for (int n = 0; n < 64 && found == 0; n++) begin
            tick();
            if (prev === 16'h0 && led_out !== 16'h0) found = 1;
            prev = led_out;
        end
        total++;
        if (found == 0) begin
            bad++;
            $display("FAIL pwm_align: no on-window seen in 64 cycles, o_led=%h", led_out);
        end else begin
            if (led_out !== 16'h00FF) begin
                bad++;
                $display("FAIL pwm_align: got %h expected 00FF", led_out);
            end
            for (int j = 1; j < 48; j++) begin
                tick();
                exp = (j < 32) ? ((j % 16 < 4) ? 16'h00FF : 16'h0) : ((j % 16 < 8) ? 16'h00FF : 16'h0);
                total++;
                if (led_out !== exp) begin
                    bad++;
                    $display("FAIL pwm_duty: sample %0d got %h expected %h", j, led_out, exp);
                end
                if (j == 22) bright = 4'd8;
            end
        end
    endtask

    task automatic test_pwm_full();
        int off = 0;
        bright = 4'd15;
        repeat (40) tick();
        repeat (16) begin
            tick();
            if (led_out !== 16'h00FF) off++;
        end
        total++;
        if (off !== 0) begin
            bad++;
            $display("FAIL pwm_full: %0d cycles not 00FF expected 0", off);
        end
        led_in = 16'hA5A5;
        tick();
        total++;
        if (led_out !== 16'h00FF) begin
            bad++;
            $display("FAIL led_lat1: got %h expected 00FF", led_out);
        end
        tick();
        total++;
        if (led_out !== 16'hA5A5) begin
            bad++;
            $display("FAIL led_lat2: got %h expected A5A5", led_out);
        end
        bright = 4'd0;
        repeat (40) tick();
        off = 0;
        repeat (16) begin
            tick();
            if (led_out !== 16'h0) off++;
        end
        total++;
        if (off !== 0) begin
            bad++;
            $display("FAIL pwm_zero: %0d cycles lit expected 0", off);
        end
        led_in = 16'h0;
    endtask

    task automatic test_uart_switch();
        logic b;
        utx = 3'b111;
        usel = 2'd0;
        repeat (3) tick();
        for (int k = 0; k < 10; k++) begin
            b = (k == 9);
            utx[0] = b;
            if (k == 0) usel = 2'd1;
            tick();
            total++;
            if (utx_out !== b || ucur !== ((k == 9) ? 2'd1 : 2'd0)) begin
                bad++;
                $display("FAIL uart_frame: bit %0d tx=%b cur=%0d expected tx=%b cur=%0d", k, utx_out, ucur, b, (k == 9) ? 1 : 0);
            end
        end
        utx = 3'b110;
        tick();
        total++;
        if (utx_out !== 1'b1) begin
            bad++;
            $display("FAIL uart_newsrc_hi: got %b expected 1", utx_out);
        end
        utx = 3'b101;
        tick();
        total++;
        if (utx_out !== 1'b0 || ucur !== 2'd1) begin
            bad++;
            $display("FAIL uart_newsrc_lo: tx=%b cur=%0d expected tx=0 cur=1", utx_out, ucur);
        end
        utx = 3'b111;
    endtask

    task automatic test_uart_oor();
        int moved = 0;
        usel = 2'd0;
        repeat (3) tick();
        total++;
        if (ucur !== 2'd0) begin
            bad++;
            $display("FAIL uart_back0: got %0d expected 0", ucur);
        end
        usel = 2'd3;
        repeat (6) begin
            tick();
            if (ucur !== 2'd0) moved++;
        end
        total++;
        if (moved !== 0) begin
            bad++;
            $display("FAIL uart_oor: cur left 0 in %0d cycles expected 0", moved);
        end
    endtask

    task automatic test_uart_retarget();
        int was1 = 0;
        usel = 2'd0;
        utx = 3'b110;
        tick();
        usel = 2'd1;
        repeat (4) begin
            tick();
            if (ucur === 2'd1) was1++;
        end
        total++;
        if (ucur !== 2'd0) begin
            bad++;
            $display("FAIL uart_busy_hold: got %0d expected 0", ucur);
        end
        usel = 2'd2;
        repeat (3) begin
            tick();
            if (ucur === 2'd1) was1++;
        end
        utx = 3'b111;
        repeat (3) begin
            tick();
            if (ucur === 2'd1) was1++;
        end
        total++;
        if (ucur !== 2'd2 || was1 !== 0) begin
            bad++;
            $display("FAIL uart_retarget: cur=%0d cycles_on_1=%0d expected cur=2 cycles_on_1=0", ucur, was1);
        end
        utx = 3'b011;
        tick();
        total++;
        if (utx_out !== 1'b0) begin
            bad++;
            $display("FAIL uart_src2: got %b expected 0", utx_out);
        end
        utx = 3'b111;
        usel = 2'd0;
        repeat (3) tick();
    endtask

    task automatic test_uart_cancel();
        int moved = 0;
        utx = 3'b110;
        usel = 2'd1;
        repeat (3) tick();
        usel = 2'd0;
        repeat (2) tick();
        utx = 3'b111;
        repeat (4) begin
            tick();
            if (ucur !== 2'd0) moved++;
        end
        total++;
        if (moved !== 0) begin
            bad++;
            $display("FAIL uart_cancel: cur left 0 in %0d cycles expected 0", moved);
        end
    endtask

    task automatic test_reset_mid();
        sw_in = 16'h008A;
        utx = 3'b110;
        usel = 2'd1;
        repeat (5) tick();
        rst = 1'b1;
        tick();
        total++;
        if (sw_out !== 16'h0 || ucur !== 2'd0 || utx_out !== 1'b1) begin
            bad++;
            $display("FAIL mid_reset: sw=%h cur=%0d tx=%b expected 0000 0 1", sw_out, ucur, utx_out);
        end
        usel = 2'd0;
        utx = 3'b111;
        rst = 1'b0;
        for (int k = 1; k <= 11; k++) begin
            tick();
            if (k == 9 || k == 10) begin
                total++;
                if (sw_out !== ((k == 10) ? 16'h008A : 16'h0)) begin
                    bad++;
                    $display("FAIL mid_redeb: cycle %0d got %h", k, sw_out);
                end
            end
            if (k == 11) begin
                total++;
                if (sw_rise !== 16'h008A) begin
                    bad++;
                    $display("FAIL mid_rise: got %h expected 008A", sw_rise);
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        sw_in = 16'hFFFF;
        utx = 3'b000;
        usel = 2'd0;
        led_in = 16'h0;
        bright = 4'd0;
        @(negedge clk);
        test_reset();
        test_debounce();
        test_glitch();
        test_simultaneous();
        test_fall();
        test_pwm();
        test_pwm_full();
        test_uart_switch();
        test_uart_oor();
        test_uart_retarget();
        test_uart_cancel();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
